// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet controller.
package router_pkg;

  localparam int ADDR_W    = 2;
  localparam int NUM_PORTS = 3;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // Header byte layout: destination address in the low bits, payload length above it.
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  // Payload length carried in a header byte.
  function automatic logic [HDR_LEN_MSB-HDR_LEN_LSB:0] hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-level controller for the 1x3 router: decodes the header address,
// sequences header/payload/parity loads into the destination FIFO, stalls on
// FIFO full and waits for a busy destination to drain.
//
// state              | meaning
// -------------------+------------------------------------------------
// DECODE_ADDRESS     | idle, looking for a header with a valid address
// LOAD_FIRST_DATA    | header byte loaded into the FIFO
// LOAD_DATA          | payload bytes being written
// FIFO_FULL_STATE    | destination full, source held
// LOAD_AFTER_FULL    | replay the byte held during full
// LOAD_PARITY        | parity byte being written
// CHECK_PARITY_ERROR | clear internal parity/error check registers
// WAIT_TILL_EMPTY    | destination FIFO still draining a previous packet
module router_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   hdr_addr;
  logic                hdr_ok;
  // Extra top bit pads the vectors to 2^ADDR_W so any 2-bit index is in range.
  logic [NUM_PORTS:0]  empty_v;
  logic [NUM_PORTS:0]  soft_v;

  assign hdr_addr = data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
  assign hdr_ok   = pkt_valid && (hdr_addr != ADDR_INVALID);
  assign empty_v  = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_v   = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

  // State and latched destination address.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next state and address latch; a soft reset of the addressed port wins over everything.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q != DECODE_ADDRESS && soft_v[addr_q]) begin
      state_d = DECODE_ADDRESS;
    end else begin
      unique case (state_q)
        DECODE_ADDRESS: begin
          if (hdr_ok) begin
            addr_d  = hdr_addr;
            state_d = empty_v[hdr_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (empty_v[addr_q]) state_d = LOAD_FIRST_DATA;
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    busy          = 1'b0;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    unique case (state_q)
      DECODE_ADDRESS:  detect_add = 1'b1;
      LOAD_FIRST_DATA: begin lfd_state = 1'b1; busy = 1'b1; end
      LOAD_DATA:       begin ld_state = 1'b1; write_enb_reg = 1'b1; end
      FIFO_FULL_STATE: begin full_state = 1'b1; busy = 1'b1; end
      LOAD_AFTER_FULL: begin laf_state = 1'b1; busy = 1'b1; write_enb_reg = 1'b1; end
      LOAD_PARITY:     begin busy = 1'b1; write_enb_reg = 1'b1; end
      CHECK_PARITY_ERROR: begin rst_int_reg = 1'b1; busy = 1'b1; end
      WAIT_TILL_EMPTY: busy = 1'b1;
      default:         detect_add = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a rule-level model.
module tb_router_fsm;

  logic       clock, resetn;
  logic       pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] empty;   // {port2, port1, port0}
    logic [2:0] srst;    // {port2, port1, port0}
    logic       pdone;
    logic       lpv;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  // Output bundle {busy, detect_add, lfd, ld, laf, full, wen, rst_int}
  localparam logic [7:0] O_DEC  = 8'h40;
  localparam logic [7:0] O_LFD  = 8'hA0;
  localparam logic [7:0] O_LD   = 8'h12;
  localparam logic [7:0] O_FULL = 8'h84;
  localparam logic [7:0] O_LAF  = 8'h8A;
  localparam logic [7:0] O_LP   = 8'h82;
  localparam logic [7:0] O_CPE  = 8'h81;
  localparam logic [7:0] O_WTE  = 8'h80;

  int vectors = 0;
  int miscompares = 0;

  function automatic in_t mk(logic pv, logic [1:0] din, logic full, logic [2:0] empty,
                             logic [2:0] srst, logic pdone, logic lpv);
    in_t v;
    v.pv = pv; v.din = din; v.full = full; v.empty = empty;
    v.srst = srst; v.pdone = pdone; v.lpv = lpv;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg};
  endfunction

  task automatic apply(input in_t v);
    pkt_valid     = v.pv;
    data_in       = v.din;
    fifo_full     = v.full;
    fifo_empty_0  = v.empty[0];
    fifo_empty_1  = v.empty[1];
    fifo_empty_2  = v.empty[2];
    soft_reset_0  = v.srst[0];
    soft_reset_1  = v.srst[1];
    soft_reset_2  = v.srst[2];
    parity_done   = v.pdone;
    low_pkt_valid = v.lpv;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL %s: outputs got %h expected %h at %0t", name, outs(), exp, $time);
    end
  endtask

  // Drive at the negedge, let one rising edge pass, check at the next negedge.
  task automatic cyc(input in_t v, input logic [7:0] exp, input string name);
    apply(v);
    @(posedge clock);
    @(negedge clock);
    check(name, exp);
  endtask

  task automatic do_reset();
    apply(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0));
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  // Reference model: packet phase names of the bench's own, advanced by the protocol rules.
  localparam int P_IDLE = 0, P_HDR = 1, P_PAY = 2, P_STALL = 3,
                 P_REPLAY = 4, P_PAR = 5, P_CHK = 6, P_WAIT = 7;
  logic [7:0] phase_out [8];

  function automatic void model_step(input int ph, input logic [1:0] a, input in_t v,
                                     output int ph_n, output logic [1:0] a_n);
    ph_n = ph;
    a_n  = a;
    if (ph != P_IDLE && v.srst[a]) begin
      ph_n = P_IDLE;
    end else if (ph == P_IDLE) begin
      if (v.pv && v.din != 2'b11) begin
        a_n  = v.din;
        ph_n = v.empty[v.din] ? P_HDR : P_WAIT;
      end
    end else if (ph == P_HDR) ph_n = P_PAY;
    else if (ph == P_PAY) begin
      if (v.full) ph_n = P_STALL;
      else if (!v.pv) ph_n = P_PAR;
    end else if (ph == P_STALL) begin
      if (!v.full) ph_n = P_REPLAY;
    end else if (ph == P_REPLAY) ph_n = v.pdone ? P_IDLE : (v.lpv ? P_PAR : P_PAY);
    else if (ph == P_PAR) ph_n = P_CHK;
    else if (ph == P_CHK) ph_n = v.full ? P_STALL : P_IDLE;
    else if (ph == P_WAIT) begin
      if (v.empty[a]) ph_n = P_HDR;
    end
  endfunction

  vec_t tbl [24];

  initial begin
    phase_out[P_IDLE] = O_DEC;  phase_out[P_HDR] = O_LFD;
    phase_out[P_PAY]  = O_LD;   phase_out[P_STALL] = O_FULL;
    phase_out[P_REPLAY] = O_LAF; phase_out[P_PAR] = O_LP;
    phase_out[P_CHK]  = O_CPE;  phase_out[P_WAIT] = O_WTE;

    tbl[0]  = '{mk(1, 2'd3, 0, 3'b111, 3'b000, 0, 0), O_DEC};   // invalid address
    tbl[1]  = '{mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 0), O_DEC};
    tbl[2]  = '{mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0), O_LFD};
    tbl[3]  = '{mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD};
    tbl[4]  = '{mk(1, 2'd0, 0, 3'b111, 3'b001, 0, 0), O_LD};    // other port's soft reset
    tbl[5]  = '{mk(1, 2'd0, 0, 3'b111, 3'b010, 0, 0), O_DEC};   // addressed soft reset
    tbl[6]  = '{mk(1, 2'd0, 0, 3'b110, 3'b000, 0, 0), O_WTE};
    tbl[7]  = '{mk(1, 2'd0, 0, 3'b110, 3'b000, 0, 0), O_WTE};
    tbl[8]  = '{mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LFD};
    tbl[9]  = '{mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_LD};    // header->payload ignores full
    tbl[10] = '{mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_FULL};
    tbl[11] = '{mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_FULL};
    tbl[12] = '{mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 1), O_LAF};
    tbl[13] = '{mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 1), O_LP};    // low_pkt_valid path
    tbl[14] = '{mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_CPE};
    tbl[15] = '{mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_FULL};  // full after parity check
    tbl[16] = '{mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LAF};
    tbl[17] = '{mk(0, 2'd0, 0, 3'b111, 3'b000, 1, 1), O_DEC};   // parity_done beats low_pkt_valid
    tbl[18] = '{mk(1, 2'd2, 0, 3'b111, 3'b000, 0, 0), O_LFD};
    tbl[19] = '{mk(1, 2'd2, 0, 3'b111, 3'b000, 0, 0), O_LD};
    tbl[20] = '{mk(0, 2'd2, 0, 3'b111, 3'b000, 0, 0), O_LP};
    tbl[21] = '{mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_CPE};
    tbl[22] = '{mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_DEC};   // back-to-back header
    tbl[23] = '{mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LFD};
  end

  initial begin
    in_t idle, v;
    int ph, ph_n;
    logic [1:0] a, a_n;

    resetn = 1'b0;
    idle = mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0);
    apply(idle);
    @(negedge clock);
    check("reset_outputs", O_DEC);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 24; i++) cyc(tbl[i].in, tbl[i].exp, $sformatf("tbl[%0d]", i));

    // Normal packet: header 8'h39 (addr 1, length 14)
    do_reset();
    cyc(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0), O_LFD, "pkt1_hdr");
    for (int i = 0; i < 14; i++)
      cyc(mk(1, 2'(i), 0, 3'b111, 3'b000, 0, 0), O_LD, $sformatf("pkt1_pay%0d", i));
    cyc(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LP,  "pkt1_parity");
    cyc(idle, O_CPE, "pkt1_check");
    cyc(idle, O_DEC, "pkt1_done");

    // Full stall on the 5th payload cycle
    cyc(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LFD, "stall_hdr");
    for (int i = 0; i < 4; i++) cyc(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD, "stall_pay");
    cyc(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_FULL, "stall_enter");
    for (int i = 0; i < 3; i++) cyc(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_FULL, "stall_hold");
    cyc(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LAF, "stall_replay");
    cyc(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD,  "stall_resume");
    cyc(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LP,  "stall_parity");
    cyc(idle, O_CPE, "stall_check");
    cyc(idle, O_DEC, "stall_done");

    // Busy destination port 2; port 0 empty flag toggles meanwhile
    cyc(mk(1, 2'd2, 0, 3'b011, 3'b000, 0, 0), O_WTE, "wait_enter");
    for (int i = 0; i < 6; i++)
      cyc(mk(0, 2'd0, 0, {2'b01, 1'(i)}, 3'b000, 0, 0), O_WTE, $sformatf("wait_hold%0d", i));
    cyc(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LFD, "wait_release");
    cyc(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD,  "wait_load");

    // Asynchronous reset in the middle of payload, seen before the next clock edge
    #2 resetn = 1'b0;
    #1 check("async_reset_outputs", O_DEC);
    vectors++;
    if (dut.addr_q !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset_addr: addr_q got %0d expected 0", dut.addr_q);
    end
    @(negedge clock);
    resetn = 1'b1;
    cyc(idle, O_DEC, "after_reset_idle");

    // Randomized traffic against the phase model
    do_reset();
    ph = P_IDLE;
    a  = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      v.pv    = ($urandom_range(0, 9) < 7);
      v.din   = 2'($urandom_range(0, 3));
      v.full  = ($urandom_range(0, 9) < 2);
      v.empty = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      v.srst  = {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)};
      v.pdone = ($urandom_range(0, 9) < 2);
      v.lpv   = ($urandom_range(0, 9) < 2);
      model_step(ph, a, v, ph_n, a_n);
      ph = ph_n;
      a  = a_n;
      cyc(v, phase_out[ph], $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Packet-level controller for the 1x3 router datapath.
- Watches the incoming byte stream (pkt_valid, header address bits) and the per-port FIFO status.
- Sequences the load of header, payload and parity into the input register and the destination router_fifo.
- Drives lfd_state, write enable, busy and register-control strobes; throttles the source on FIFO full and waits for a busy destination FIFO to drain.

Parameters:
none; three output ports and a 2-bit address field are fixed (address 2'b11 is invalid).

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  source asserts for header and payload bytes; deasserts with the parity byte
data_in  in  2  header address bits, data_in[1:0] of the current byte
parity_done  in  1  parity byte has been captured by the register block
low_pkt_valid  in  1  register block saw pkt_valid fall while a byte was pending after full
fifo_full  in  1  full flag of the currently addressed FIFO (pre-muxed by the sync block)
fifo_empty_0  in  1  empty flag, port 0
fifo_empty_1  in  1  empty flag, port 1
fifo_empty_2  in  1  empty flag, port 2
soft_reset_0  in  1  soft reset, port 0
soft_reset_1  in  1  soft reset, port 1
soft_reset_2  in  1  soft reset, port 2
busy  out  1  source must hold its current byte
detect_add  out  1  FSM is decoding a header
lfd_state  out  1  header byte being loaded into the FIFO
ld_state  out  1  payload byte being loaded
laf_state  out  1  load-after-full: replay the byte held during full
full_state  out  1  destination FIFO full
write_enb_reg  out  1  write strobe to the destination FIFO
rst_int_reg  out  1  clear internal parity/error check registers

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- Moore outputs, decoded from the state register only. Every output not listed for a state is 0.
  - DECODE_ADDRESS: detect_add=1
  - LOAD_FIRST_DATA: lfd_state=1, busy=1
  - LOAD_DATA: ld_state=1, write_enb_reg=1
  - FIFO_FULL_STATE: full_state=1, busy=1
  - LOAD_AFTER_FULL: laf_state=1, busy=1, write_enb_reg=1
  - LOAD_PARITY: busy=1, write_enb_reg=1
  - CHECK_PARITY_ERROR: rst_int_reg=1, busy=1
  - WAIT_TILL_EMPTY: busy=1
- Address latch addr_q (2b): loaded from data_in in DECODE_ADDRESS when pkt_valid=1 and data_in!=2'b11.
- Transitions, one clock each:
  - DECODE_ADDRESS: pkt_valid & valid addr & fifo_empty[data_in] -> LOAD_FIRST_DATA. pkt_valid & valid addr & !fifo_empty[data_in] -> WAIT_TILL_EMPTY. Otherwise (including addr 2'b11) stay.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditional.
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA; else stay.
- Soft reset: soft_reset[addr_q]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next edge. It overrides all other transition conditions. Soft resets on non-addressed ports are ignored.
- resetn=0, including mid-packet: state -> DECODE_ADDRESS and addr_q -> 0 immediately. Outputs at reset: detect_add=1, all others 0.
- Back-to-back packets: from CHECK_PARITY_ERROR, DECODE_ADDRESS is reached on the following edge. A header present that cycle is decoded normally.

Decomposition:
- Package router_pkg holds:
  - the state enum typedef (8 states, 3-bit encoding)
  - ADDR_W=2, NUM_PORTS=3, ADDR_INVALID=2'b11
  - the header field positions (addr [1:0], payload length [7:2])
- Single module; no sub-module is natural. State register, next-state logic, address latch and output decode stay in router_fsm.

Test Plan:
- Reset: resetn=0 mid-LOAD_DATA -> detect_add=1, all other outputs 0, state DECODE_ADDRESS immediately; addr_q=0.
- Normal packet to port 1: fifo_empty_1=1, header 8'h39 (len 14, addr 1) with pkt_valid=1 -> lfd_state=1 one cycle, then ld_state/write_enb_reg=1 for 14 cycles. When pkt_valid drops: LOAD_PARITY (busy=1) -> CHECK_PARITY_ERROR (rst_int_reg=1) -> detect_add=1.
- Full stall: fifo_full=1 on 5th payload cycle -> full_state=1, busy=1, write_enb_reg=0 while full. Release -> laf_state=1 one cycle. With parity_done=0 and low_pkt_valid=0 -> back to LOAD_DATA.
- Busy destination: header addr 2, fifo_empty_2=0 -> WAIT_TILL_EMPTY, busy=1. Set fifo_empty_2=1 after 6 cycles -> LOAD_FIRST_DATA next edge. fifo_empty_0 toggling in between has no effect.
- Invalid address: header addr 2'b11 with pkt_valid=1 -> stays DECODE_ADDRESS, no write_enb_reg, addr_q unchanged.
- Soft reset: during LOAD_DATA on port 1, soft_reset_0=1 -> no effect. soft_reset_1=1 -> DECODE_ADDRESS next edge, write_enb_reg=0.
